alu_arbiter: RTL and testbench

- Shares one `alu_top` instance between two requesters (e.g. decode-side issue and a multi-cycle helper) using valid/ready handshakes on both request and response.
- Arbitrates round-robin and registers operands into the ALU.
- Captures the 33-bit ALU result and returns it only to the requester that issued it.
- Sits between the requesters and `alu_top`; `alu_top` is instantiated outside this block and driven through the `alu_*` ports.

---
 rtl/alu_pkg.sv | 22 ++
 rtl/rr_arb2.sv | 11 +
 rtl/alu_arbiter.sv | 128 ++++++++++++
 tb/tb_alu_arbiter.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared definitions for the ALU arbiter slice: widths, opcodes and FSM encoding.
package alu_pkg;
  localparam int XLEN   = 32;
  localparam int OP_W   = 4;
  localparam int OP_MAX = 8;

  localparam logic [OP_W-1:0] OP_ADD = 4'd0;
  localparam logic [OP_W-1:0] OP_SUB = 4'd1;
  localparam logic [OP_W-1:0] OP_XOR = 4'd2;
  localparam logic [OP_W-1:0] OP_OR  = 4'd3;
  localparam logic [OP_W-1:0] OP_AND = 4'd4;
  localparam logic [OP_W-1:0] OP_SLL = 4'd5;
  localparam logic [OP_W-1:0] OP_SRL = 4'd6;
  localparam logic [OP_W-1:0] OP_SRA = 4'd7;
  localparam logic [OP_W-1:0] OP_SLT = 4'd8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_e;
endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin grant; on a tie the requester that did not win last time gets it.
module rr_arb2 (
  input  logic v0,
  input  logic v1,
  input  logic last_grant,
  output logic gnt,
  output logic any
);
  assign any = v0 | v1;
  assign gnt = (v0 & v1) ? ~last_grant : v1;
endmodule

// File: rtl/alu_arbiter.sv
// Shares one external ALU between two valid/ready requesters; round-robin
// issue, two-cycle latency, result returned only to the issuing requester.
module alu_arbiter #(
  parameter int XLEN   = alu_pkg::XLEN,
  parameter int OP_W   = alu_pkg::OP_W,
  parameter int OP_MAX = alu_pkg::OP_MAX
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            req0_valid_i,
  output logic            req0_ready_o,
  input  logic [OP_W-1:0] req0_instr_i,
  input  logic [XLEN-1:0] req0_src1_i,
  input  logic [XLEN-1:0] req0_src2_i,
  input  logic            req1_valid_i,
  output logic            req1_ready_o,
  input  logic [OP_W-1:0] req1_instr_i,
  input  logic [XLEN-1:0] req1_src1_i,
  input  logic [XLEN-1:0] req1_src2_i,
  output logic            rsp0_valid_o,
  input  logic            rsp0_ready_i,
  output logic [XLEN:0]   rsp0_result_o,
  output logic            rsp0_err_o,
  output logic            rsp1_valid_o,
  input  logic            rsp1_ready_i,
  output logic [XLEN:0]   rsp1_result_o,
  output logic            rsp1_err_o,
  output logic [OP_W-1:0] alu_instr_o,
  output logic [XLEN-1:0] alu_src1_o,
  output logic [XLEN-1:0] alu_src2_o,
  input  logic [XLEN:0]   alu_result_i
);
  import alu_pkg::*;

  state_e          state_q;
  logic            last_q;
  logic            owner_q;
  logic            illegal_q;
  logic [OP_W-1:0] instr_q;
  logic [XLEN-1:0] src1_q, src2_q;
  logic [XLEN:0]   res_q;
  logic            err_q;
  logic [1:0]      rsp_vld_q;

  logic            gnt, gnt_any, owner_rdy, window, accept;
  logic [OP_W-1:0] sel_instr;
  logic [XLEN-1:0] sel_src1, sel_src2;
  logic            sel_illegal;

  rr_arb2 u_arb (
    .v0         (req0_valid_i),
    .v1         (req1_valid_i),
    .last_grant (last_q),
    .gnt        (gnt),
    .any        (gnt_any)
  );

  // The window reopens in RESP on the cycle the owner drains its result,
  // which is what allows back-to-back issue every two cycles.
  assign owner_rdy = owner_q ? rsp1_ready_i : rsp0_ready_i;
  assign window    = (state_q == IDLE) || (state_q == RESP && owner_rdy);
  assign accept    = window & gnt_any;

  assign req0_ready_o = accept & ~gnt & req0_valid_i;
  assign req1_ready_o = accept &  gnt & req1_valid_i;

  always_comb begin
    sel_instr = gnt ? req1_instr_i : req0_instr_i;
    sel_src1  = gnt ? req1_src1_i  : req0_src1_i;
    sel_src2  = gnt ? req1_src2_i  : req0_src2_i;
    sel_illegal = sel_instr > OP_W'(OP_MAX);
  end

  // Operand registers only move on accept, so the ALU inputs stay quiet
  // outside EXEC. Illegal opcodes run as a harmless ADD 0,0.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      instr_q   <= OP_ADD;
      src1_q    <= '0;
      src2_q    <= '0;
      illegal_q <= 1'b0;
      owner_q   <= 1'b0;
      last_q    <= 1'b1;
    end else if (accept) begin
      instr_q   <= sel_illegal ? OP_ADD : sel_instr;
      src1_q    <= sel_illegal ? '0 : sel_src1;
      src2_q    <= sel_illegal ? '0 : sel_src2;
      illegal_q <= sel_illegal;
      owner_q   <= gnt;
      last_q    <= gnt;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= IDLE;
      res_q     <= '0;
      err_q     <= 1'b0;
      rsp_vld_q <= 2'b00;
    end else begin
      case (state_q)
        IDLE: if (accept) state_q <= EXEC;
        EXEC: begin
          res_q   <= illegal_q ? '0 : alu_result_i;
          err_q   <= illegal_q;
          rsp_vld_q[owner_q] <= 1'b1;
          state_q <= RESP;
        end
        RESP: if (owner_rdy) begin
          rsp_vld_q <= 2'b00;
          state_q   <= accept ? EXEC : IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign alu_instr_o = instr_q;
  assign alu_src1_o  = src1_q;
  assign alu_src2_o  = src2_q;

  assign rsp0_valid_o  = rsp_vld_q[0];
  assign rsp1_valid_o  = rsp_vld_q[1];
  assign rsp0_result_o = rsp_vld_q[0] ? res_q : '0;
  assign rsp1_result_o = rsp_vld_q[1] ? res_q : '0;
  assign rsp0_err_o    = rsp_vld_q[0] & err_q;
  assign rsp1_err_o    = rsp_vld_q[1] & err_q;
endmodule

// File: tb/tb_alu_arbiter.sv
// Scoreboard bench for alu_arbiter with a behavioural stand-in for alu_top.
module tb_alu_arbiter;
  logic        clk_i = 1'b0, rst_i = 1'b1;
  logic        req0_valid_i = 0, req1_valid_i = 0, req0_ready_o, req1_ready_o;
  logic [3:0]  req0_instr_i = 0, req1_instr_i = 0;
  logic [31:0] req0_src1_i = 0, req0_src2_i = 0, req1_src1_i = 0, req1_src2_i = 0;
  logic        rsp0_valid_o, rsp1_valid_o, rsp0_ready_i = 1, rsp1_ready_i = 1;
  logic [32:0] rsp0_result_o, rsp1_result_o, alu_result_i;
  logic        rsp0_err_o, rsp1_err_o;
  logic [3:0]  alu_instr_o;
  logic [31:0] alu_src1_o, alu_src2_o;

  int total = 0, passed = 0;
  logic [33:0] q0[$], q1[$];

  alu_arbiter dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .req0_valid_i(req0_valid_i), .req0_ready_o(req0_ready_o), .req0_instr_i(req0_instr_i),
    .req0_src1_i(req0_src1_i), .req0_src2_i(req0_src2_i),
    .req1_valid_i(req1_valid_i), .req1_ready_o(req1_ready_o), .req1_instr_i(req1_instr_i),
    .req1_src1_i(req1_src1_i), .req1_src2_i(req1_src2_i),
    .rsp0_valid_o(rsp0_valid_o), .rsp0_ready_i(rsp0_ready_i), .rsp0_result_o(rsp0_result_o),
    .rsp0_err_o(rsp0_err_o),
    .rsp1_valid_o(rsp1_valid_o), .rsp1_ready_i(rsp1_ready_i), .rsp1_result_o(rsp1_result_o),
    .rsp1_err_o(rsp1_err_o),
    .alu_instr_o(alu_instr_o), .alu_src1_o(alu_src1_o), .alu_src2_o(alu_src2_o),
    .alu_result_i(alu_result_i)
  );

  always #5 clk_i = ~clk_i;

  // Stand-in for the external alu_top: 33-bit signed result, combinational.
  always_comb begin
    logic [32:0] a, b;
    a = {alu_src1_o[31], alu_src1_o};
    b = {alu_src2_o[31], alu_src2_o};
    alu_result_i = '0;
    case (alu_instr_o)
      4'd0: alu_result_i = a + b;
      4'd1: alu_result_i = a - b;
      4'd2: alu_result_i = a ^ b;
      4'd3: alu_result_i = a | b;
      4'd4: alu_result_i = a & b;
      4'd5: alu_result_i = {1'b0, alu_src1_o << alu_src2_o[4:0]};
      4'd6: alu_result_i = {1'b0, alu_src1_o >> alu_src2_o[4:0]};
      4'd7: alu_result_i = $signed(a) >>> alu_src2_o[4:0];
      4'd8: alu_result_i = {32'd0, $signed(alu_src1_o) < $signed(alu_src2_o)};
      default: alu_result_i = '0;
    endcase
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s actual=%h required=%h", name, act, exp);
  endtask

  // Monitor: every consumed response must match the head of its queue.
  always @(negedge clk_i) begin
    if (!rst_i) begin
      if (rsp0_valid_o && rsp1_valid_o) chk("rsp_both_valid", 1, 0);
      if (rsp0_valid_o && rsp0_ready_i) begin
        if (q0.size() == 0) chk("rsp0_unexpected", {rsp0_err_o, rsp0_result_o}, 64'hDEAD);
        else chk("rsp0", {rsp0_err_o, rsp0_result_o}, q0.pop_front());
      end
      if (rsp1_valid_o && rsp1_ready_i) begin
        if (q1.size() == 0) chk("rsp1_unexpected", {rsp1_err_o, rsp1_result_o}, 64'hDEAD);
        else chk("rsp1", {rsp1_err_o, rsp1_result_o}, q1.pop_front());
      end
    end
  end

  task automatic send(input int r, input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                      input logic [32:0] er, input logic ee);
    bit got = 0;
    if (r == 0) begin req0_instr_i = op; req0_src1_i = a; req0_src2_i = b; req0_valid_i = 1; end
    else        begin req1_instr_i = op; req1_src1_i = a; req1_src2_i = b; req1_valid_i = 1; end
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk_i);
      if (r == 0 ? req0_ready_o : req1_ready_o) begin
        got = 1;
        if (r == 0) q0.push_back({ee, er}); else q1.push_back({ee, er});
      end
    end
    if (!got) chk("accept_timeout", 0, 1);
    @(posedge clk_i); #1;
    if (r == 0) req0_valid_i = 0; else req1_valid_i = 0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk_i);
    #1;
  endtask

  task automatic pulse_reset();
    @(posedge clk_i); #1 rst_i = 1;
    @(posedge clk_i); #1 rst_i = 0;
  endtask

  initial begin
    int g[$];
    // reset state
    @(negedge clk_i); @(negedge clk_i);
    chk("reset_hs", {req0_ready_o, req1_ready_o, rsp0_valid_o, rsp1_valid_o, rsp0_err_o, rsp1_err_o}, 0);
    chk("reset_res", {rsp0_result_o, rsp1_result_o}, 0);
    chk("reset_alu", {alu_instr_o, alu_src1_o, alu_src2_o}, 0);
    @(posedge clk_i); #1 rst_i = 0;

    // ADD 20,15 from req0; two-cycle latency
    send(0, 4'd0, 32'd20, 32'd15, 33'd35, 0);
    @(negedge clk_i);
    chk("t1_exec_novalid", rsp0_valid_o, 0);
    chk("t1_exec_src1", alu_src1_o, 20);
    @(negedge clk_i);
    chk("t1_rsp0_valid", rsp0_valid_o, 1);
    chk("t1_rsp1_quiet", rsp1_valid_o, 0);
    idle(2);

    // SUB -1,15 from req1
    send(1, 4'd1, 32'hFFFF_FFFF, 32'd15, 33'h1_FFFF_FFF0, 0);
    @(negedge clk_i);
    chk("t2_alu_instr", alu_instr_o, 1);
    idle(3);

    // continuous tie from reset: grants alternate starting at req0
    pulse_reset();
    req0_instr_i = 0; req0_src1_i = 1; req0_src2_i = 2;
    req1_instr_i = 0; req1_src1_i = 3; req1_src2_i = 4;
    req0_valid_i = 1; req1_valid_i = 1;
    for (int i = 0; i < 40 && g.size() < 4; i++) begin
      @(negedge clk_i);
      if (req0_ready_o && req1_ready_o) chk("t3_both_ready", 1, 0);
      else if (req0_ready_o) begin g.push_back(0); q0.push_back({1'b0, 33'd3}); end
      else if (req1_ready_o) begin g.push_back(1); q1.push_back({1'b0, 33'd7}); end
    end
    @(posedge clk_i); #1 req0_valid_i = 0; req1_valid_i = 0;
    chk("t3_grant_count", g.size(), 4);
    for (int i = 0; i < g.size(); i++) chk("t3_grant_order", g[i], i % 2);
    idle(4);

    // backpressure on rsp0, then same-edge handoff to req1
    rsp0_ready_i = 0;
    send(0, 4'd2, 32'h0000_F0F0, 32'h0000_0FF0, 33'h0_0000_FF00, 0);
    req1_instr_i = 4'd3; req1_src1_i = 32'h00F0; req1_src2_i = 32'h0F00; req1_valid_i = 1;
    @(negedge clk_i);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk_i);
      chk("t4_hold_valid", rsp0_valid_o, 1);
      chk("t4_hold_result", rsp0_result_o, 33'h0_0000_FF00);
      chk("t4_no_ready", {req0_ready_o, req1_ready_o}, 0);
    end
    @(posedge clk_i); #1 rsp0_ready_i = 1;
    @(negedge clk_i);
    chk("t4_handoff_ready", req1_ready_o, 1);
    if (req1_ready_o) q1.push_back({1'b0, 33'h0_0000_0FF0});
    @(posedge clk_i); #1 req1_valid_i = 0;
    idle(4);

    // illegal opcode
    send(1, 4'd12, 32'd5, 32'd6, 33'd0, 1);
    @(negedge clk_i);
    chk("t5_alu_forced", {alu_instr_o, alu_src1_o, alu_src2_o}, 0);
    idle(4);

    // async reset during EXEC
    req0_instr_i = 0; req0_src1_i = 7; req0_src2_i = 8; req0_valid_i = 1;
    @(negedge clk_i);
    chk("t6_accept", req0_ready_o, 1);
    @(posedge clk_i); #1 req0_valid_i = 0;
    #2 rst_i = 1;
    #1 chk("t6_async_clear", {req0_ready_o, req1_ready_o, rsp0_valid_o, rsp1_valid_o}, 0);
    @(posedge clk_i); #1 rst_i = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk_i);
      chk("t6_no_rsp", {rsp0_valid_o, rsp1_valid_o}, 0);
    end
    @(posedge clk_i); #1;
    req0_src1_i = 1; req0_src2_i = 2; req1_src1_i = 3; req1_src2_i = 4;
    req0_valid_i = 1; req1_valid_i = 1;
    @(negedge clk_i);
    chk("t6_tie_to_req0", {req0_ready_o, req1_ready_o}, 2'b10);
    if (req0_ready_o) q0.push_back({1'b0, 33'd3});
    @(posedge clk_i); #1 req0_valid_i = 0; req1_valid_i = 0;

    for (int i = 0; i < 20 && (q0.size() + q1.size()) != 0; i++) @(posedge clk_i);
    idle(2);
    chk("drain", q0.size() + q1.size(), 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
